// File: rtl/adc_conv_ctrl.sv
// Conversion sequencer for a 4-bit clocked ADC: generates adc_clk, averages 2^AVG_LOG2 codes, valid/ready result.
// Optional build macro ADC_CONV_CTRL_DOUT_SYNC_EN adds a 2-flop synchronizer on adc_dout.
module adc_conv_ctrl #(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned AVG_LOG2 = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       cont,
    output logic       adc_clk,
    input  logic [3:0] adc_dout,
    output logic [3:0] res_data,
    output logic       res_valid,
    input  logic       res_ready,
    output logic       busy
);

    localparam int unsigned AW = 4 + AVG_LOG2;
    localparam int unsigned N  = 1 << AVG_LOG2;

    typedef enum logic [1:0] {IDLE, CLK_HI, CLK_LO, DONE} state_t;

    state_t              state;
    logic [7:0]          div_cnt;
    logic [AVG_LOG2:0]   smp_cnt;
    logic [AW-1:0]       acc;
    logic [AW-1:0]       sum;
    logic [3:0]          cap;
    logic                div_last;

`ifdef ADC_CONV_CTRL_DOUT_SYNC_EN
    logic [3:0] sync1;
    logic [3:0] sync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= adc_dout;
            sync2 <= sync1;
        end
    end

    always_comb cap = sync2;
`else
    always_comb cap = adc_dout;
`endif

    always_comb begin
        div_last = (div_cnt == 8'(CLK_DIV - 1));
        sum      = acc + AW'(cap);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            div_cnt   <= '0;
            smp_cnt   <= '0;
            acc       <= '0;
            adc_clk   <= 1'b0;
            res_data  <= '0;
            res_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    adc_clk <= 1'b0;
                    if (start) begin
                        acc     <= '0;
                        smp_cnt <= '0;
                        div_cnt <= '0;
                        adc_clk <= 1'b1;
                        busy    <= 1'b1;
                        state   <= CLK_HI;
                    end
                end
                CLK_HI: begin
                    if (div_last) begin
                        div_cnt <= '0;
                        adc_clk <= 1'b0;
                        state   <= CLK_LO;
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                CLK_LO: begin
                    if (div_last) begin
                        // Capture edge: the final sample goes straight into the result via sum.
                        div_cnt <= '0;
                        acc     <= sum;
                        smp_cnt <= smp_cnt + 1'b1;
                        if (smp_cnt == (AVG_LOG2 + 1)'(N - 1)) begin
                            res_data  <= 4'(sum >> AVG_LOG2);
                            res_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            adc_clk <= 1'b1;
                            state   <= CLK_HI;
                        end
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                DONE: begin
                    adc_clk <= 1'b0;
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        if (cont) begin
                            acc     <= '0;
                            smp_cnt <= '0;
                            div_cnt <= '0;
                            adc_clk <= 1'b1;
                            state   <= CLK_HI;
                        end else begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    adc_clk <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_conv_ctrl.sv
// Scoreboard bench for adc_conv_ctrl: default instance plus an AVG_LOG2=0 instance.
module tb_adc_conv_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, start, cont, res_ready;
    logic [3:0] adc_dout;
    logic       adc_clk, res_valid, busy;
    logic [3:0] res_data;

    logic       start2;
    logic [3:0] adc_dout2;
    logic       adc_clk2, res_valid2, busy2;
    logic [3:0] res_data2;

    adc_conv_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cont(cont),
        .adc_clk(adc_clk), .adc_dout(adc_dout),
        .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
        .busy(busy)
    );

    adc_conv_ctrl #(.CLK_DIV(4), .AVG_LOG2(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .cont(1'b0),
        .adc_clk(adc_clk2), .adc_dout(adc_dout2),
        .res_data(res_data2), .res_valid(res_valid2), .res_ready(1'b1),
        .busy(busy2)
    );

    int tests = 0;
    int fails = 0;
    int exp_q[$];
    int exp_q2[$];
    int rises = 0;
    logic adc_prev = 1'b0;
    logic v_prev = 1'b0;
    logic v2_prev = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (adc_clk && !adc_prev) rises <= rises + 1;
        adc_prev <= adc_clk;
    end

    // Monitors: a result is presented on each rising edge of res_valid.
    always @(negedge clk) begin
        v_prev <= res_valid;
        if (rst_n && res_valid && !v_prev) begin
            if (exp_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_result: got %0d expected none", res_data);
            end else begin
                check("res_data", int'(res_data), exp_q.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        v2_prev <= res_valid2;
        if (rst_n && res_valid2 && !v2_prev) begin
            if (exp_q2.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_result2: got %0d expected none", res_data2);
            end else begin
                check("res_data2", int'(res_data2), exp_q2.pop_front());
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!res_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!res_valid) begin
            tests++; fails++;
            $display("FAIL wait_valid: got timeout expected res_valid");
        end
    endtask

    task automatic wait_fall();
        int   t;
        logic p;
        t = 0;
        p = adc_clk;
        while (t < 100) begin
            @(negedge clk);
            t++;
            if (p && !adc_clk) break;
            p = adc_clk;
        end
        if (t >= 100) begin
            tests++; fails++;
            $display("FAIL wait_fall: got timeout expected adc_clk fall");
        end
    endtask

    initial begin
        #200000;
        fails++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, n2, r0, ok, exp_sync;
        int vals[4];
        vals[0] = 1; vals[1] = 2; vals[2] = 3; vals[3] = 5;

        rst_n = 1'b0; start = 1'b0; cont = 1'b0; res_ready = 1'b1;
        adc_dout = '0; start2 = 1'b0; adc_dout2 = '0;
        repeat (3) @(negedge clk);
        check("rst_adc_clk", adc_clk, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", res_data, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;

        // Constant code
        adc_dout = 4'hA; exp_q.push_back(10); r0 = rises;
        pulse_start();
        check("adc_clk_after_start", adc_clk, 1);
        check("busy_after_start", busy, 1);
        wait_valid(n);
        check("latency_const", n, 32);
        repeat (3) @(negedge clk);
        check("busy_idle_const", busy, 0);
        check("rises_const", rises - r0, 4);

        // Averaging 1,2,3,5 -> 11>>2
        exp_q.push_back(2);
        pulse_start();
        for (int k = 0; k < 4; k++) begin
            wait_fall();
            adc_dout = 4'(vals[k]);
        end
        wait_valid(n);
        repeat (2) @(negedge clk);

        // Single-sample instance
        adc_dout2 = 4'd7; exp_q2.push_back(7);
        @(negedge clk); start2 = 1'b1;
        @(negedge clk); start2 = 1'b0;
        n = 0;
        while (!res_valid2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("latency_avg0", n, 8);
        repeat (3) @(negedge clk);
        check("busy2_idle", busy2, 0);

        // Backpressure
        adc_dout = 4'd8; exp_q.push_back(8); res_ready = 1'b0;
        pulse_start();
        wait_valid(n);
        ok = 1;
        repeat (10) begin
            @(negedge clk);
            if (!res_valid || res_data != 4'd8 || adc_clk) ok = 0;
        end
        check("backpressure_hold", ok, 1);
        check("backpressure_busy", busy, 1);
        res_ready = 1'b1;
        @(negedge clk);
        check("handshake_clears_valid", res_valid, 0);
        check("handshake_busy", busy, 0);

        // Continuous mode, cont dropped during the second result
        adc_dout = 4'd3; cont = 1'b1;
        exp_q.push_back(3); exp_q.push_back(12);
        pulse_start();
        wait_valid(n);
        check("latency_cont1", n, 32);
        adc_dout = 4'd12;
        @(negedge clk);
        check("cont_valid_pulse", res_valid, 0);
        check("cont_busy", busy, 1);
        cont = 1'b0;
        wait_valid(n2);
        check("cont_period", n2 + 1, 33);
        @(negedge clk);
        check("cont_drop_valid", res_valid, 0);
        check("cont_drop_busy", busy, 0);
        r0 = rises;
        repeat (10) @(negedge clk);
        check("cont_drop_idle_rises", rises - r0, 0);

        // Start while busy is ignored
        adc_dout = 4'd6; exp_q.push_back(6);
        pulse_start();
        repeat (5) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_valid(n);
        check("latency_start_busy", n + 6, 32);
        repeat (10) @(negedge clk);
        check("start_busy_no_queue", busy, 0);

        // Reset during the third high phase
        adc_dout = 4'd15;
        pulse_start();
        repeat (18) @(negedge clk);
        check("third_hi_adc_clk", adc_clk, 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_adc_clk", adc_clk, 0);
        check("async_rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        adc_dout = 4'd6; exp_q.push_back(6); r0 = rises;
        pulse_start();
        wait_valid(n);
        check("latency_after_rst", n, 32);
        repeat (2) @(negedge clk);
        check("rises_after_rst", rises - r0, 4);

        // Change 5->9 so that only the last two edges before the final capture see 9
`ifdef ADC_CONV_CTRL_DOUT_SYNC_EN
        exp_sync = 5;
`else
        exp_sync = 6;
`endif
        adc_dout = 4'd5; exp_q.push_back(exp_sync);
        pulse_start();
        repeat (30) @(negedge clk);
        adc_dout = 4'd9;
        wait_valid(n);
        check("latency_sync", n + 30, 32);
        repeat (3) @(negedge clk);

        check("scoreboard_empty", exp_q.size() + exp_q2.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
